// File: rtl/ddr_pkg.sv
// ddr_pkg: refresh FSM encoding and default DDR timing constants shared across the controller.
package ddr_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_ISSUE = 2'd2,
    ST_WAIT  = 2'd3
  } ref_state_t;
  localparam int TREFI_CYC_DEF = 780;
  localparam int TRFC_CYC_DEF  = 8;
endpackage

// File: rtl/ddr_down_counter.sv
// ddr_down_counter: loadable down counter with zero flag; load has priority over decrement.
module ddr_down_counter #(
  parameter int              WIDTH   = 12,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_zero
);
  logic [WIDTH-1:0] r_cnt;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_cnt <= RST_VAL;
    else if (i_load) r_cnt <= i_load_val;
    else if (i_en) r_cnt <= r_cnt - 1'b1;
  assign o_zero = r_cnt == '0;
endmodule

// File: rtl/ddr_refresh_ctrl.sv
// ddr_refresh_ctrl: periodic AUTO REFRESH generator and rfc_req/ack/end handshake with the scheduler.
// Define REFRESH_POSTPONE_EN to batch owed refreshes into scheduler idle gaps.
module ddr_refresh_ctrl
  import ddr_pkg::*;
#(
  parameter int TREFI_CYC = TREFI_CYC_DEF,
  parameter int TRFC_CYC  = TRFC_CYC_DEF,
  parameter int MAX_PEND  = 8,
  parameter int PEND_HI   = 4,
  parameter int CNT_W     = 12
) (
  input  logic       clock_i,
  input  logic       reset_ni,
  input  logic       enable_i,
  input  logic       idle_hint_i,
  output logic       rfc_req_o,
  input  logic       rfc_ack_i,
  output logic       rfc_end_o,
  input  logic       cmd_gnt_i,
  output logic       ddr_ref_o,
  output logic [3:0] pend_o,
  output logic       overrun_o
);
  localparam logic [3:0]       LP_MAX  = 4'(MAX_PEND);
  localparam logic [CNT_W-1:0] LP_REFI = CNT_W'(TREFI_CYC - 1);
  localparam logic [CNT_W-1:0] LP_RFC  = CNT_W'(TRFC_CYC - 1);
  ref_state_t r_state, w_next;
  logic [3:0] r_pend;
  logic       r_ovr, r_ref;
  logic       w_refi_zero, w_rfc_zero, w_tick, w_issue, w_rfc_done, w_req_cond;
  ddr_down_counter #(.WIDTH(CNT_W), .RST_VAL(LP_REFI)) u_refi (
    .i_clk(clock_i), .i_rst_n(reset_ni), .i_load(!enable_i || w_refi_zero),
    .i_load_val(LP_REFI), .i_en(enable_i), .o_zero(w_refi_zero)
  );
  // tRFC is timed from the REFRESH command cycle, hence the hold while ddr_ref_o is high
  ddr_down_counter #(.WIDTH(CNT_W), .RST_VAL(LP_RFC)) u_rfc (
    .i_clk(clock_i), .i_rst_n(reset_ni), .i_load(w_issue), .i_load_val(LP_RFC),
    .i_en(r_state == ST_WAIT && !r_ref && !w_rfc_zero), .o_zero(w_rfc_zero)
  );
  assign w_tick     = enable_i && w_refi_zero;
  assign w_issue    = r_state == ST_ISSUE && cmd_gnt_i;
  assign w_rfc_done = r_state == ST_WAIT && !r_ref && w_rfc_zero;
`ifdef REFRESH_POSTPONE_EN
  assign w_req_cond = (r_pend >= 4'(PEND_HI)) || (r_pend != '0 && idle_hint_i);
`else
  logic w_unused;
  assign w_unused   = idle_hint_i | (PEND_HI == 0);
  assign w_req_cond = r_pend != '0;
`endif
  always_ff @(posedge clock_i or negedge reset_ni)
    if (!reset_ni) r_state <= ST_IDLE;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  w_next = w_req_cond ? ST_REQ : ST_IDLE;
      ST_REQ:   w_next = rfc_ack_i ? ST_ISSUE : ST_REQ;
      ST_ISSUE: w_next = cmd_gnt_i ? ST_WAIT : ST_ISSUE;
      ST_WAIT:  w_next = w_rfc_done ? ST_IDLE : ST_WAIT;
      default:  w_next = ST_IDLE;
    endcase
    if (!enable_i) w_next = ST_IDLE;
  end
  always_comb begin
    rfc_req_o = r_state == ST_REQ;
    rfc_end_o = r_state == ST_IDLE || r_state == ST_REQ;
  end
  // a tick coinciding with an issue cancels out; overrun still flags a tick at MAX_PEND
  always_ff @(posedge clock_i or negedge reset_ni)
    if (!reset_ni) begin
      r_pend <= '0;
      r_ovr  <= 1'b0;
      r_ref  <= 1'b0;
    end else if (!enable_i) begin
      r_pend <= '0;
      r_ovr  <= 1'b0;
      r_ref  <= 1'b0;
    end else begin
      r_ref  <= w_issue;
      r_ovr  <= r_ovr | (w_tick && r_pend == LP_MAX);
      r_pend <= (w_tick && !w_issue && r_pend != LP_MAX) ? r_pend + 4'd1 :
                (w_issue && !w_tick) ? r_pend - 4'd1 : r_pend;
    end
  assign ddr_ref_o = r_ref;
  assign pend_o    = r_pend;
  assign overrun_o = r_ovr;
endmodule

// File: tb/tb_ddr_refresh_ctrl.sv
// tb_ddr_refresh_ctrl: directed checks of the refresh controller with TREFI_CYC=100, TRFC_CYC=8.
module tb_ddr_refresh_ctrl;
`ifdef REFRESH_POSTPONE_EN
  localparam bit POSTPONE = 1'b1;
`else
  localparam bit POSTPONE = 1'b0;
`endif
  logic       clk = 1'b0, rst_n = 1'b0, enable = 1'b0, idle_hint = 1'b1, ack = 1'b0, gnt = 1'b1;
  logic       req, rend, ref_o, ovr;
  logic [3:0] pend;
  int n_vec = 0, n_err = 0;
  int m_refi = 99, tick_cnt = 0, ref_total = 0;
  int low, rc, viol, seen, drop, ovr_tick, pend_at_ovr, t0, r0;
  always #5 clk = ~clk;
  ddr_refresh_ctrl #(.TREFI_CYC(100), .TRFC_CYC(8), .MAX_PEND(8), .PEND_HI(4), .CNT_W(12)) dut (
    .clock_i(clk), .reset_ni(rst_n), .enable_i(enable), .idle_hint_i(idle_hint),
    .rfc_req_o(req), .rfc_ack_i(ack), .rfc_end_o(rend), .cmd_gnt_i(gnt),
    .ddr_ref_o(ref_o), .pend_o(pend), .overrun_o(ovr)
  );
  // reference interval counter: a tick happens on the edge where m_refi is 0
  always @(posedge clk or negedge rst_n)
    if (!rst_n) m_refi <= 99;
    else if (!enable) m_refi <= 99;
    else begin
      if (m_refi == 0) tick_cnt <= tick_cnt + 1;
      m_refi <= (m_refi == 0) ? 99 : m_refi - 1;
    end
  always @(posedge clk) if (ref_o) ref_total <= ref_total + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic wait_req();
    for (int i = 0; i < 400 && !req; i++) @(negedge clk);
    chk("req_timeout", req, 1);
  endtask
  task automatic serve();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    gnt = 1'b1;
    for (int i = 0; i < 40 && !rend; i++) @(negedge clk);
    chk("end_timeout", rend, 1);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_req", req, 0);
    chk("rst_end", rend, 1);
    chk("rst_ref", ref_o, 0);
    chk("rst_pend", pend, 0);
    chk("rst_ovr", ovr, 0);
    rst_n = 1'b1;
    enable = 1'b1;
    // 1: first refresh
    repeat (99) @(negedge clk);
    chk("t1_pend_pre", pend, 0);
    @(negedge clk);
    chk("t1_pend_tick", pend, 1);
    chk("t1_req_pre", req, 0);
    @(negedge clk);
    chk("t1_req_rise", req, 1);
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("t1_req_ack", req, 0);
    chk("t1_end_ack", rend, 0);
    low = 0; rc = 0; viol = 0;
    for (int i = 0; i < 30; i++) begin
      if (!rend) low++;
      if (ref_o) rc++;
      if (req && !rend) viol++;
      @(negedge clk);
    end
    chk("t1_end_low", low, 10);
    chk("t1_ref_pulses", rc, 1);
    chk("t1_req_vs_end", viol, 0);
    chk("t1_pend_done", pend, 0);
    // 2: no ack, saturation and overrun
    t0 = tick_cnt; seen = 0; drop = 0; ovr_tick = -1; pend_at_ovr = -1;
    for (int i = 0; i < 900; i++) begin
      @(negedge clk);
      if (req) seen = 1;
      else if (seen != 0) drop++;
      if (ovr && ovr_tick < 0) begin
        ovr_tick = tick_cnt - t0;
        pend_at_ovr = pend;
      end
    end
    chk("t2_req_seen", seen, 1);
    chk("t2_req_held", drop, 0);
    chk("t2_ovr_tick", ovr_tick, 9);
    chk("t2_pend_at_ovr", pend_at_ovr, 8);
    chk("t2_pend_sat", pend, 8);
    chk("t2_ovr", ovr, 1);
    // 3: grant withheld
    gnt = 1'b0;
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("t3_end_ack", rend, 0);
    low = 0; rc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!rend) low++;
      if (ref_o) rc++;
    end
    chk("t3_end_held", low, 20);
    chk("t3_no_ref", rc, 0);
    if (m_refi == 0) @(negedge clk);
    gnt = 1'b1;
    @(negedge clk);
    chk("t3_ref_on_gnt", ref_o, 1);
    chk("t3_pend_dec", pend, 7);
    chk("t3_ovr_sticky", ovr, 1);
    for (int i = 0; i < 40 && !rend; i++) @(negedge clk);
    chk("t3_end_back", rend, 1);
    // 4: tick coincident with issue at pend 3
    for (int g = 0; g < 30; g++) begin
      wait_req();
      if (m_refi == 0) @(negedge clk);
      if (pend == 4'd3) break;
      serve();
    end
    chk("t4_pend_pre", pend, 3);
    gnt = 1'b0;
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    for (int i = 0; i < 110 && m_refi != 0; i++) @(negedge clk);
    chk("t4_pend_wait", pend, 3);
    gnt = 1'b1;
    @(negedge clk);
    chk("t4_ref", ref_o, 1);
    chk("t4_pend_same", pend, 3);
    for (int i = 0; i < 40 && !rend; i++) @(negedge clk);
    chk("t4_end_back", rend, 1);
    // 5: disable during WAIT
    wait_req();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    @(negedge clk);
    chk("t5_ref", ref_o, 1);
    repeat (3) @(negedge clk);
    chk("t5_in_wait", rend, 0);
    enable = 1'b0;
    idle_hint = 1'b0;
    @(negedge clk);
    chk("t5_end", rend, 1);
    chk("t5_pend", pend, 0);
    chk("t5_ovr", ovr, 0);
    chk("t5_req", req, 0);
    enable = 1'b1;
    repeat (99) @(negedge clk);
    chk("t5_no_tick_99", pend, 0);
    @(negedge clk);
    chk("t5_tick_100", pend, 1);
    @(negedge clk);
    chk("t6_req_at_1", req, POSTPONE ? 0 : 1);
    // 6: postponement
`ifdef REFRESH_POSTPONE_EN
    repeat (299) @(negedge clk);
    chk("t6_pend_hi", pend, 4);
    chk("t6_req_pre", req, 0);
    @(negedge clk);
    chk("t6_req_hi", req, 1);
    r0 = ref_total;
    serve();
    @(negedge clk);
    chk("t6_no_req_below_hi", req, 0);
    idle_hint = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_req();
      serve();
    end
    @(negedge clk);
    chk("t6_batch_refs", ref_total - r0, 4);
    chk("t6_batch_pend", pend, 0);
    for (int i = 0; i < 150 && pend == 4'd0; i++) @(negedge clk);
    chk("t6_pend_one", pend, 1);
    @(negedge clk);
    chk("t6_hint_req", req, 1);
`else
    r0 = ref_total;
    serve();
    @(negedge clk);
    chk("t6_refs", ref_total - r0, 1);
    chk("t6_pend", pend, 0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
